// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS instruction fetch front end: FSM states, the
// queued entry layout and the default reset fetch address.
package mips_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched instructions. Head outputs come straight from
// storage registers, so nothing on the write side reaches them combinationally.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output logic                     head_valid_o,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full buffer is only legal when the head leaves this cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  // NOTE: the storage is reset because the head is visible on the outputs and
  // must read as zero out of reset; it is only a handful of entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, runs the single-outstanding imem handshake and
// feeds returned words into fetch_fifo; a redirect flushes and refetches.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   dec_valid,
  output logic [31:0]            dec_instr,
  output logic [31:0]            dec_pc_4,
  input  logic                   dec_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   stale_addr_q, stale_addr_d;
  logic          push, pop, flush;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] post_count;

  assign imem_req  = (state_q != ST_IDLE);
  // A dropped request keeps presenting its original address until it is acked.
  assign imem_addr = (state_q == ST_DISCARD) ? stale_addr_q : fetch_pc_q;
  assign pop       = dec_valid && dec_ready && !redirect;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    push         = 1'b0;
    flush        = 1'b0;
    push_entry   = '{instr: imem_rdata, pc_4: fetch_pc_q + 32'd4};
    post_count   = count + CW'(1) - CW'(pop);

    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_pc & ~32'd3;
      unique case (state_q)
        ST_IDLE:    state_d = ST_FETCH;
        ST_FETCH: begin
          if (!imem_ack) begin
            state_d      = ST_DISCARD;
            stale_addr_d = fetch_pc_q;
          end
        end
        ST_DISCARD: if (imem_ack) state_d = ST_FETCH;
        default:    state_d = ST_IDLE;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE:    if (count < FULL) state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (post_count >= FULL) state_d = ST_IDLE;
          end
        end
        ST_DISCARD: if (imem_ack) state_d = ST_FETCH;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .flush_i      (flush),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .head_valid_o (dec_valid),
    .head_o       (head),
    .count_o      (count)
  );

  assign dec_instr = head.instr;
  assign dec_pc_4  = head.pc_4;

endmodule
